// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl: routes shared buttons and the display to the clock, stopwatch or cook timer,
// and lets a ringing cook timer take over until it is acknowledged, falls silent or times out.
module watch_mode_ctrl #(
  parameter int ALARM_TO = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [3:0] btn_pedge,
  input  logic       timer_alarm,
  input  logic [7:0] watch_hour,
  input  logic [7:0] watch_min,
  input  logic [7:0] sw_sec,
  input  logic [7:0] sw_csec,
  input  logic [7:0] tmr_min,
  input  logic [7:0] tmr_sec,
  output logic [2:0] watch_btn,
  output logic [2:0] sw_btn,
  output logic [2:0] tmr_btn,
  output logic [1:0] mode,
  output logic [2:0] mode_led,
  output logic [7:0] disp_hi,
  output logic [7:0] disp_lo,
  output logic       alarm_ack
);
  typedef enum logic [1:0] {S_WATCH, S_STOPWATCH, S_TIMER, S_ALARM} state_t;
  localparam logic [29:0] TO_LAST = 30'(ALARM_TO - 1);
  state_t state, state_n;
  logic [1:0] ret_mode, ret_n;
  logic [29:0] cnt, cnt_n;
  logic alarm_q, rise, ack_n;
  logic [2:0] fn, watch_n, sw_n, tmr_n;
  logic [7:0] hi_n, lo_n;
  assign rise = timer_alarm & ~alarm_q;
  assign fn = btn_pedge[3:1];
  assign mode = state;
  assign mode_led = state == S_ALARM ? 3'b111 : 3'b001 << state;
  always_comb begin
    state_n = state;
    ret_n = ret_mode;
    cnt_n = '0;
    ack_n = 1'b0;
    watch_n = '0;
    sw_n = '0;
    tmr_n = '0;
    hi_n = state == S_WATCH ? watch_hour : state == S_STOPWATCH ? sw_sec : tmr_min;
    lo_n = state == S_WATCH ? watch_min : state == S_STOPWATCH ? sw_csec : tmr_sec;
    if (state == S_ALARM) begin
      cnt_n = cnt + 30'd1;
      // a button and the timeout together still give a single acknowledge
      if (|btn_pedge || cnt == TO_LAST) begin
        ack_n = 1'b1;
        state_n = state_t'(ret_mode);
      end else if (!timer_alarm) state_n = state_t'(ret_mode);
      if (state_n != S_ALARM) cnt_n = '0;
    end else if (rise) begin
      ret_n = state;
      state_n = S_ALARM;
    end else if (btn_pedge[0]) state_n = state == S_TIMER ? S_WATCH : state_t'(state + 2'd1);
    else begin
      watch_n = state == S_WATCH ? fn : 3'd0;
      sw_n = state == S_STOPWATCH ? fn : 3'd0;
      tmr_n = state == S_TIMER ? fn : 3'd0;
    end
  end
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state <= S_WATCH;
      ret_mode <= '0;
      cnt <= '0;
      alarm_q <= 1'b0;
      alarm_ack <= 1'b0;
      watch_btn <= '0;
      sw_btn <= '0;
      tmr_btn <= '0;
      disp_hi <= '0;
      disp_lo <= '0;
    end else begin
      state <= state_n;
      ret_mode <= ret_n;
      cnt <= cnt_n;
      alarm_q <= timer_alarm;
      alarm_ack <= ack_n;
      watch_btn <= watch_n;
      sw_btn <= sw_n;
      tmr_btn <= tmr_n;
      disp_hi <= hi_n;
      disp_lo <= lo_n;
    end
  end
endmodule

// File: tb/tb_watch_mode_ctrl.sv
// tb_watch_mode_ctrl: directed scenarios plus random traffic against a behavioural mode model.
module tb_watch_mode_ctrl;
  localparam int TO = 20;
  logic clk = 0, reset_p = 0, timer_alarm = 0;
  logic [3:0] btn_pedge = 0;
  logic [7:0] watch_hour = 8'h12, watch_min = 8'h34, sw_sec = 8'h56, sw_csec = 8'h78, tmr_min = 8'h9a, tmr_sec = 8'hbc;
  logic [2:0] watch_btn, sw_btn, tmr_btn, mode_led;
  logic [1:0] mode;
  logic [7:0] disp_hi, disp_lo;
  logic alarm_ack;
  int passed = 0, total = 0;

  watch_mode_ctrl #(.ALARM_TO(TO)) dut (
    .clk(clk), .reset_p(reset_p), .btn_pedge(btn_pedge), .timer_alarm(timer_alarm),
    .watch_hour(watch_hour), .watch_min(watch_min), .sw_sec(sw_sec), .sw_csec(sw_csec),
    .tmr_min(tmr_min), .tmr_sec(tmr_sec), .watch_btn(watch_btn), .sw_btn(sw_btn),
    .tmr_btn(tmr_btn), .mode(mode), .mode_led(mode_led), .disp_hi(disp_hi),
    .disp_lo(disp_lo), .alarm_ack(alarm_ack)
  );

  always #5 clk = ~clk;

  // model: the selected function mode persists underneath an alarm overlay
  int m_mode, m_el;
  bit m_alarm, m_prev, m_ack;
  logic [2:0] m_wb, m_sb, m_tb;
  logic [7:0] m_hi, m_lo;
  always @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      m_mode <= 0; m_el <= 0; m_alarm <= 0; m_prev <= 0; m_ack <= 0;
      m_wb <= 0; m_sb <= 0; m_tb <= 0; m_hi <= 0; m_lo <= 0;
    end else begin
      automatic bit rise = timer_alarm && !m_prev;
      automatic bit route = !m_alarm && !rise && !btn_pedge[0];
      automatic bit done = m_alarm && (btn_pedge != 0 || m_el + 1 == TO);
      m_prev <= timer_alarm;
      m_wb <= route && m_mode == 0 ? btn_pedge[3:1] : 3'd0;
      m_sb <= route && m_mode == 1 ? btn_pedge[3:1] : 3'd0;
      m_tb <= route && m_mode == 2 ? btn_pedge[3:1] : 3'd0;
      m_hi <= m_alarm || m_mode == 2 ? tmr_min : m_mode == 1 ? sw_sec : watch_hour;
      m_lo <= m_alarm || m_mode == 2 ? tmr_sec : m_mode == 1 ? sw_csec : watch_min;
      m_ack <= done;
      if (m_alarm) begin
        m_el <= m_el + 1;
        if (done || !timer_alarm) m_alarm <= 0;
      end else if (rise) begin
        m_alarm <= 1; m_el <= 0;
      end else if (btn_pedge[0]) m_mode <= (m_mode + 1) % 3;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] b);
    btn_pedge = b;
    tick();
    btn_pedge = 0;
  endtask

  task automatic test_reset;
    reset_p = 1;
    #1;
    total++; if ({mode, mode_led, watch_btn, sw_btn, tmr_btn, alarm_ack} !== {2'd0, 3'b001, 10'd0})
      $display("FAIL reset_outputs got %h want %h", {mode, mode_led, watch_btn, sw_btn, tmr_btn, alarm_ack}, {2'd0, 3'b001, 10'd0}); else passed++;
    tick(); tick();
    reset_p = 0;
    #1;
    total++; if ({disp_hi, disp_lo} !== 16'h0) $display("FAIL reset_disp got %h want 0000", {disp_hi, disp_lo}); else passed++;
    tick();
    total++; if ({disp_hi, disp_lo} !== 16'h1234) $display("FAIL first_disp got %h want 1234", {disp_hi, disp_lo}); else passed++;
  endtask

  task automatic test_mode_cycle;
    logic [1:0] em[5] = '{0, 1, 2, 0, 1};
    logic [2:0] el[5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        pulse(4'b0001);
        repeat (4) tick();
      end
      total++; if ({mode, mode_led} !== {em[i], el[i]})
        $display("FAIL mode_cycle[%0d] got %0d/%b want %0d/%b", i, mode, mode_led, em[i], el[i]); else passed++;
    end
  endtask

  task automatic test_routing;
    pulse(4'b0100);
    total++; if ({watch_btn, sw_btn, tmr_btn} !== 9'b000_010_000)
      $display("FAIL route_sw got %b want 000010000", {watch_btn, sw_btn, tmr_btn}); else passed++;
    tick();
    total++; if (sw_btn !== 3'b000) $display("FAIL route_width got %b want 000", sw_btn); else passed++;
    pulse(4'b0101);
    total++; if ({mode, watch_btn, sw_btn, tmr_btn} !== {2'd2, 9'd0})
      $display("FAIL mode_wins got %0d/%b want 2/000000000", mode, {watch_btn, sw_btn, tmr_btn}); else passed++;
    pulse(4'b0001);
    pulse(4'b0001);
  endtask

  task automatic test_alarm_ack;
    timer_alarm = 1;
    tick();
    total++; if ({mode, mode_led} !== {2'd3, 3'b111}) $display("FAIL alarm_entry got %0d/%b want 3/111", mode, mode_led); else passed++;
    tick();
    total++; if ({disp_hi, disp_lo} !== {tmr_min, tmr_sec})
      $display("FAIL alarm_disp got %h want %h", {disp_hi, disp_lo}, {tmr_min, tmr_sec}); else passed++;
    pulse(4'b0100);
    total++; if ({alarm_ack, mode, sw_btn} !== {1'b1, 2'd1, 3'd0})
      $display("FAIL alarm_ack got %b/%0d/%b want 1/1/000", alarm_ack, mode, sw_btn); else passed++;
    tick();
    total++; if (alarm_ack !== 1'b0) $display("FAIL ack_width got %b want 0", alarm_ack); else passed++;
    timer_alarm = 0;
    tick();
  endtask

  task automatic test_timeout;
    pulse(4'b0001);
    pulse(4'b0001);
    timer_alarm = 1;
    tick();
    for (int k = 1; k < TO; k++) begin
      tick();
      total++; if ({mode, alarm_ack} !== {2'd3, 1'b0})
        $display("FAIL timeout_wait[%0d] got %0d/%b want 3/0", k, mode, alarm_ack); else passed++;
    end
    tick();
    total++; if ({mode, alarm_ack} !== {2'd0, 1'b1}) $display("FAIL timeout_ack got %0d/%b want 0/1", mode, alarm_ack); else passed++;
    repeat (10) tick();
    total++; if (mode !== 2'd0) $display("FAIL held_no_reentry got %0d want 0", mode); else passed++;
    timer_alarm = 0; tick();
    timer_alarm = 1; tick();
    total++; if (mode !== 2'd3) $display("FAIL reentry got %0d want 3", mode); else passed++;
    timer_alarm = 0; tick();
    total++; if ({mode, alarm_ack} !== {2'd0, 1'b0}) $display("FAIL fall_exit got %0d/%b want 0/0", mode, alarm_ack); else passed++;
  endtask

  task automatic test_fall;
    pulse(4'b0001);
    pulse(4'b0001);
    timer_alarm = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) timer_alarm = 0;
      total++; if ({mode, alarm_ack} !== {2'd3, 1'b0}) $display("FAIL fall_hold[%0d] got %0d/%b want 3/0", k, mode, alarm_ack); else passed++;
    end
    tick();
    total++; if ({mode, alarm_ack} !== {2'd2, 1'b0}) $display("FAIL fall_return got %0d/%b want 2/0", mode, alarm_ack); else passed++;
  endtask

  task automatic test_reset_mid_alarm;
    bit seen = 0;
    timer_alarm = 1;
    tick();
    repeat (TO - 3) tick();
    #2 reset_p = 1;
    #1;
    total++; if ({mode, alarm_ack} !== {2'd0, 1'b0}) $display("FAIL async_reset got %0d/%b want 0/0", mode, alarm_ack); else passed++;
    timer_alarm = 0;
    tick();
    reset_p = 0;
    repeat (TO + 5) begin
      tick();
      if (alarm_ack !== 1'b0 || mode !== 2'd0) seen = 1;
    end
    total++; if (seen) $display("FAIL post_reset_ack got ack/mode activity want none"); else passed++;
    reset_p = 1;
    timer_alarm = 1;
    tick();
    reset_p = 0;
    tick();
    total++; if (mode !== 2'd3) $display("FAIL alarm_at_release got %0d want 3", mode); else passed++;
    pulse(4'b0001);
    total++; if ({mode, alarm_ack} !== {2'd0, 1'b1}) $display("FAIL mode_btn_ack got %0d/%b want 0/1", mode, alarm_ack); else passed++;
    timer_alarm = 0;
    tick();
  endtask

  task automatic test_random;
    logic [30:0] obs, exp;
    for (int i = 0; i < 2000; i++) begin
      btn_pedge = $urandom_range(0, 4) == 0 ? 4'($urandom) : 4'd0;
      if ($urandom_range(0, 30) == 0) timer_alarm = ~timer_alarm;
      {watch_hour, watch_min, sw_sec, sw_csec} = $urandom;
      {tmr_min, tmr_sec} = 16'($urandom);
      tick();
      obs = {mode, mode_led, watch_btn, sw_btn, tmr_btn, alarm_ack, disp_hi, disp_lo};
      exp = {m_alarm ? 2'd3 : 2'(m_mode), m_alarm ? 3'b111 : 3'(1 << m_mode), m_wb, m_sb, m_tb, m_ack, m_hi, m_lo};
      total++; if (obs !== exp) $display("FAIL random[%0d] got %h want %h", i, obs, exp); else passed++;
    end
    btn_pedge = 0;
  endtask

  initial begin
    #1;
    test_reset();
    test_mode_cycle();
    test_routing();
    test_alarm_ack();
    test_timeout();
    test_fall();
    test_reset_mid_alarm();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
